// File: rtl/wb_stage.sv
// wb_stage: write-back stage with register file, data memory, bypassed read ports, PC redirect and retire counter
module wb_stage #(
  parameter int DMEM_DEPTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_reg_write,
  input  logic             wb_mem_to_reg,
  input  logic             wb_mem_write,
  input  logic             wb_pcsrc,
  input  logic [7:0]       wb_result,
  input  logic [7:0]       wb_data2,
  input  logic [2:0]       wb_write_addr,
  input  logic [2:0]       rs1_addr,
  input  logic [2:0]       rs2_addr,
  output logic [7:0]       rs1_data,
  output logic [7:0]       rs2_data,
  output logic [7:0]       wb_data,
  output logic             pc_redirect,
  output logic [7:0]       pc_target,
  output logic [CNT_W-1:0] retire_count
);
  localparam int AW = $clog2(DMEM_DEPTH);
  logic [7:0] regs [8];
  logic [7:0] dmem [DMEM_DEPTH];
  logic [AW-1:0] idx;
  logic [7:0] wb_val;
  logic retire;
  assign idx = wb_result[AW-1:0];
  assign wb_val = wb_mem_to_reg ? dmem[idx] : wb_result;
  assign retire = wb_reg_write | wb_mem_write | wb_pcsrc;
  // regs[0] is never written, so it always reads back as zero
  always_comb begin
    rs1_data = !reset || rs1_addr == 3'd0 ? 8'd0 :
               wb_reg_write && wb_write_addr == rs1_addr ? wb_val : regs[rs1_addr];
    rs2_data = !reset || rs2_addr == 3'd0 ? 8'd0 :
               wb_reg_write && wb_write_addr == rs2_addr ? wb_val : regs[rs2_addr];
    wb_data = reset ? wb_val : 8'd0;
    pc_redirect = reset & wb_pcsrc;
    pc_target = reset ? wb_result : 8'd0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    else if (wb_reg_write && wb_write_addr != 3'd0)
      regs[wb_write_addr] <= wb_val;
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= '0;
    else if (wb_mem_write)
      dmem[idx] <= wb_data2;
  always_ff @(posedge clk or negedge reset)
    if (!reset)
      retire_count <= '0;
    else if (retire && retire_count != {CNT_W{1'b1}})
      retire_count <= retire_count + 1'b1;
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: scoreboard bench for wb_stage against a behavioural reference model
module tb_wb_stage;
  logic clk = 0, reset = 0;
  logic wb_reg_write = 0, wb_mem_to_reg = 0, wb_mem_write = 0, wb_pcsrc = 0;
  logic [7:0] wb_result = 0, wb_data2 = 0;
  logic [2:0] wb_write_addr = 0, rs1_addr = 0, rs2_addr = 0;
  logic [7:0] rs1_data, rs2_data, wb_data, pc_target;
  logic pc_redirect;
  logic [3:0] retire_count;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic [7:0] r1, r2, wd, pt;
    logic pr;
    logic [3:0] cnt;
  } exp_t;
  exp_t q[$];
  int mregs[8], mdmem[16], mcnt;
  bit done = 0;
  wb_stage #(.DMEM_DEPTH(16), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
    .wb_mem_write(wb_mem_write), .wb_pcsrc(wb_pcsrc), .wb_result(wb_result), .wb_data2(wb_data2),
    .wb_write_addr(wb_write_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .wb_data(wb_data), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .retire_count(retire_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask
  // Applies one cycle of inputs, queues the expected outputs, then advances the model past the edge
  task automatic cyc(input bit rst, input bit rw, input bit m2r, input bit mw, input bit pc,
                     input int res, input int d2, input int wa, input int a1, input int a2);
    exp_t e;
    int wd;
    @(negedge clk);
    reset = rst; wb_reg_write = rw; wb_mem_to_reg = m2r; wb_mem_write = mw; wb_pcsrc = pc;
    wb_result = 8'(res); wb_data2 = 8'(d2); wb_write_addr = 3'(wa); rs1_addr = 3'(a1); rs2_addr = 3'(a2);
    if (!rst) begin
      e = '{r1: 0, r2: 0, wd: 0, pt: 0, pr: 0, cnt: 0};
      foreach (mregs[i]) mregs[i] = 0;
      foreach (mdmem[i]) mdmem[i] = 0;
      mcnt = 0;
      q.push_back(e);
      return;
    end
    wd = m2r ? mdmem[res % 16] : res % 256;
    e.wd = 8'(wd);
    e.r1 = a1 == 0 ? 8'd0 : (rw && wa == a1) ? 8'(wd) : 8'(mregs[a1]);
    e.r2 = a2 == 0 ? 8'd0 : (rw && wa == a2) ? 8'(wd) : 8'(mregs[a2]);
    e.pr = pc;
    e.pt = 8'(res);
    e.cnt = 4'(mcnt);
    q.push_back(e);
    if (rw && wa != 0) mregs[wa] = wd;
    if (mw) mdmem[res % 16] = d2 % 256;
    if ((rw || mw || pc) && mcnt < 15) mcnt++;
  endtask
  task automatic bubble(input int a1, input int a2);
    cyc(1, 0, 0, 0, 0, $urandom_range(255), $urandom_range(255), $urandom_range(7), a1, a2);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("rs1_data", rs1_data, e.r1);
        chk("rs2_data", rs2_data, e.r2);
        chk("wb_data", wb_data, e.wd);
        chk("pc_redirect", pc_redirect, e.pr);
        chk("pc_target", pc_target, e.pt);
        chk("retire_count", retire_count, e.cnt);
      end
    end
  end
  initial begin : driver
    bit rw, mw, pc;
    cyc(0, 1, 1, 1, 1, 'hA5, 'h77, 7, 3, 5);
    cyc(0, 1, 0, 1, 0, 'h13, 'h11, 2, 2, 2);
    for (int i = 1; i < 8; i++) bubble(i, 8 - i);
    cyc(1, 1, 0, 0, 0, 'h5A, 0, 3, 3, 0);
    bubble(3, 0);
    cyc(1, 1, 0, 0, 0, 'hFF, 0, 0, 0, 0);
    bubble(1, 0);
    cyc(1, 0, 0, 1, 0, 'h13, 'h3C, 1, 0, 0);
    cyc(1, 1, 1, 0, 0, 'h03, 0, 5, 5, 0);
    bubble(5, 3);
    cyc(1, 1, 1, 1, 0, 'h03, 'h99, 6, 6, 5);
    cyc(1, 0, 1, 0, 0, 'h23, 0, 0, 6, 0);
    cyc(1, 0, 0, 0, 1, 'h40, 0, 4, 4, 0);
    bubble(4, 6);
    for (int i = 0; i < 250; i++)
      cyc($urandom_range(60) != 0, $urandom_range(1), $urandom_range(1), $urandom_range(1),
          $urandom_range(3) == 0, $urandom_range(255), $urandom_range(255), $urandom_range(7),
          $urandom_range(7), $urandom_range(7));
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      {rw, mw, pc} = 3'($urandom_range(1, 7));
      cyc(1, rw, $urandom_range(1), mw, pc, $urandom_range(255), $urandom_range(255),
          $urandom_range(7), $urandom_range(7), $urandom_range(7));
    end
    bubble(1, 2);
    cyc(0, 1, 0, 0, 0, 'h55, 0, 2, 2, 2);
    bubble(2, 2);
    cyc(1, 0, 0, 0, 0, 0, 0, 2, 2, 1);
    repeat (3) @(negedge clk);
    #3;
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
